// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum accumulation buffer.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_t;

    // A sum carried one bit wider than its target has overflowed exactly
    // when its two top bits disagree, whatever the target width is.
    function automatic sat_t saturate_kind(input logic [1:0] top2);
        case (top2)
            2'b01:   return SAT_POS;
            2'b10:   return SAT_NEG;
            default: return SAT_NONE;
        endcase
    endfunction

    function automatic int elem_lsb(input int lane, input int elem, input int n_elem, input int out_bit);
        return (lane * n_elem + elem) * out_bit;
    endfunction

endpackage

// File: rtl/psum_ram_sdp.sv
// Simple dual-port partial-sum store: one write port, one registered read port.
module psum_ram_sdp #(
    parameter int DATA_W   = 768,
    parameter int DEPTH    = 1024,
    parameter int ADDR_BIT = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_BIT-1:0] waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_BIT-1:0] raddr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rd_data <= mem[raddr];
    end

endmodule

// File: rtl/psum_accum_buffer.sv
// Accumulates PE partial sums across input-channel passes, adds bias on the
// first pass and emits saturated, optionally ReLU'd results on the last pass.
module psum_accum_buffer
    import psum_pkg::*;
#(
    parameter int X_PE        = 16,
    parameter int RESULT_SIZE = 2,
    parameter int OUT_BIT     = 24,
    parameter int BIAS_BIT    = 20,
    parameter int DEPTH       = 1024,
    parameter int PASS_BIT    = 8,
    localparam int ADDR_BIT   = $clog2(DEPTH),
    localparam int LANE_W     = OUT_BIT * RESULT_SIZE * RESULT_SIZE,
    localparam int DATA_W     = LANE_W * X_PE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [PASS_BIT-1:0]      cfg_num_pass,
    input  logic [ADDR_BIT:0]        cfg_tile_count,
    input  logic                     cfg_relu,
    input  logic [BIAS_BIT*X_PE-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);

    localparam int NE     = RESULT_SIZE * RESULT_SIZE;
    localparam int NE_TOT = NE * X_PE;
    localparam logic [OUT_BIT-1:0] MAX_V = {1'b0, {(OUT_BIT-1){1'b1}}};
    localparam logic [OUT_BIT-1:0] MIN_V = {1'b1, {(OUT_BIT-1){1'b0}}};

    state_t                   state_reg;
    logic [PASS_BIT-1:0]      num_pass_reg, pass_cnt_reg;
    logic [ADDR_BIT:0]        tile_count_reg;
    logic [ADDR_BIT-1:0]      tile_cnt_reg, s0_addr_reg;
    logic                     relu_reg, drain_cnt_reg;
    logic [BIAS_BIT*X_PE-1:0] bias_reg;
    logic                     s0_valid_reg, s0_first_reg, s0_last_reg, s0_final_reg;
    logic [DATA_W-1:0]        s0_data_reg, fwd_data_reg, rd_data, s1_sum, s1_res;
    logic                     fwd_hit_reg;
    logic [NE_TOT-1:0]        clamp_vec;
    logic                     accept, tile_wrap, pass_last, ram_we, ram_re;

    assign cfg_ready = (state_reg == IDLE);
    assign in_ready  = (state_reg == RUN);
    assign busy      = (state_reg != IDLE);
    assign accept    = in_valid && in_ready;
    assign tile_wrap = ({1'b0, tile_cnt_reg} == tile_count_reg - (ADDR_BIT+1)'(1));
    assign pass_last = (pass_cnt_reg == num_pass_reg - PASS_BIT'(1));
    // First-pass beats take bias instead of stored data; last-pass beats are never stored.
    assign ram_re    = accept && (pass_cnt_reg != '0);
    assign ram_we    = s0_valid_reg && !s0_last_reg;

    psum_ram_sdp #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_BIT (ADDR_BIT)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (s0_addr_reg),
        .wdata   (s1_sum),
        .re      (ram_re),
        .raddr   (tile_cnt_reg),
        .rd_data (rd_data)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NE_TOT; gi++) begin : g_elem
            localparam int LANE = gi / NE;
            localparam int LSB  = elem_lsb(gi / NE, gi % NE, NE, OUT_BIT);
            logic [BIAS_BIT-1:0]     b;
            logic [OUT_BIT-1:0]      acc, sat;
            logic signed [OUT_BIT:0] in_ext, add_ext, sum;
            sat_t                    kind;

            assign b       = bias_reg[LANE*BIAS_BIT +: BIAS_BIT];
            assign acc     = fwd_hit_reg ? fwd_data_reg[LSB +: OUT_BIT] : rd_data[LSB +: OUT_BIT];
            assign in_ext  = {s0_data_reg[LSB+OUT_BIT-1], s0_data_reg[LSB +: OUT_BIT]};
            assign add_ext = s0_first_reg ? {{(OUT_BIT+1-BIAS_BIT){b[BIAS_BIT-1]}}, b}
                                          : {acc[OUT_BIT-1], acc};
            assign sum     = in_ext + add_ext;
            assign kind    = saturate_kind(sum[OUT_BIT -: 2]);
            assign sat     = (kind == SAT_POS) ? MAX_V :
                             (kind == SAT_NEG) ? MIN_V : sum[OUT_BIT-1:0];
            assign clamp_vec[gi]           = (kind != SAT_NONE);
            assign s1_sum[LSB +: OUT_BIT]  = sat;
            assign s1_res[LSB +: OUT_BIT]  = (relu_reg && sat[OUT_BIT-1]) ? '0 : sat;
        end
    endgenerate

    // Datapath stage registers; only consumed when s0_valid_reg qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_data_reg  <= in_data;
            s0_first_reg <= (pass_cnt_reg == '0);
            s0_last_reg  <= pass_last;
            s0_final_reg <= pass_last && tile_wrap;
            s0_addr_reg  <= tile_cnt_reg;
            // The RAM returns the old word when this read meets the S1 write.
            fwd_hit_reg  <= ram_we && (s0_addr_reg == tile_cnt_reg);
            fwd_data_reg <= s1_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            num_pass_reg   <= '0;
            pass_cnt_reg   <= '0;
            tile_count_reg <= '0;
            tile_cnt_reg   <= '0;
            relu_reg       <= 1'b0;
            bias_reg       <= '0;
            drain_cnt_reg  <= 1'b0;
            s0_valid_reg   <= 1'b0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= '0;
            done           <= 1'b0;
            sat_flag       <= 1'b0;
        end else begin
            done         <= 1'b0;
            s0_valid_reg <= accept;
            out_valid    <= s0_valid_reg && s0_last_reg;
            out_last     <= s0_valid_reg && s0_final_reg;
            if (s0_valid_reg) begin
                if (|clamp_vec)
                    sat_flag <= 1'b1;
                if (s0_last_reg)
                    out_data <= s1_res;
            end

            case (state_reg)
                IDLE: begin
                    if (cfg_valid) begin
                        state_reg      <= RUN;
                        num_pass_reg   <= (cfg_num_pass == '0) ? PASS_BIT'(1) : cfg_num_pass;
                        tile_count_reg <= (cfg_tile_count == '0 || cfg_tile_count > (ADDR_BIT+1)'(DEPTH))
                                          ? (ADDR_BIT+1)'(DEPTH) : cfg_tile_count;
                        relu_reg       <= cfg_relu;
                        bias_reg       <= bias;
                        tile_cnt_reg   <= '0;
                        pass_cnt_reg   <= '0;
                        sat_flag       <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (tile_wrap) begin
                            tile_cnt_reg <= '0;
                            pass_cnt_reg <= pass_cnt_reg + PASS_BIT'(1);
                            if (pass_last) begin
                                state_reg     <= DRAIN;
                                drain_cnt_reg <= 1'b0;
                            end
                        end else begin
                            tile_cnt_reg <= tile_cnt_reg + ADDR_BIT'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg) begin
                        state_reg <= IDLE;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench for psum_accum_buffer with two lanes and a 16-word store.
module tb_psum_accum_buffer;

    localparam int X_PE = 2, RS = 2, OB = 24, BB = 20, DEPTH = 16, PB = 8;
    localparam int AB = $clog2(DEPTH);
    localparam int NE = RS * RS;
    localparam int DW = OB * NE * X_PE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [PB-1:0]     cfg_num_pass = '0;
    logic [AB:0]       cfg_tile_count = '0;
    logic              cfg_relu = 1'b0;
    logic [BB*X_PE-1:0] bias = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              sat_flag;

    psum_accum_buffer #(
        .X_PE(X_PE), .RESULT_SIZE(RS), .OUT_BIT(OB), .BIAS_BIT(BB), .DEPTH(DEPTH), .PASS_BIT(PB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_pass(cfg_num_pass), .cfg_tile_count(cfg_tile_count), .cfg_relu(cfg_relu),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] out_q[$];
    bit            last_q[$];
    int            cyc_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_drive = 0;
    logic [DW-1:0] stim[$];

    always @(negedge clk) begin
        if (out_valid) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
            cyc_q.push_back(cycle);
            $display("[%0d] out beat %0d data=%h last=%0b", cycle, out_q.size() - 1, out_data, out_last);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cycle;
        end
    end

    function automatic logic [DW-1:0] pack_lanes(input int l0, input int l1);
        logic [DW-1:0] d;
        d = '0;
        for (int e = 0; e < NE; e++) begin
            d[e*OB +: OB]      = OB'(l0);
            d[(NE+e)*OB +: OB] = OB'(l1);
        end
        return d;
    endfunction

    function automatic logic [BB*X_PE-1:0] pack_bias(input int b0, input int b1);
        return {BB'(b1), BB'(b0)};
    endfunction

    function automatic int gval(input int p, input int t, input int lane, input int e);
        return p * 1000 + t * 7 + e * 3 + lane * 100 - 500;
    endfunction

    function automatic logic [DW-1:0] gap_data(input int p, input int t);
        logic [DW-1:0] d;
        for (int l = 0; l < X_PE; l++)
            for (int e = 0; e < NE; e++)
                d[(l*NE+e)*OB +: OB] = OB'(gval(p, t, l, e));
        return d;
    endfunction

    function automatic logic [DW-1:0] gap_exp(input int t, input int b0, input int b1);
        logic [DW-1:0] d;
        for (int l = 0; l < X_PE; l++)
            for (int e = 0; e < NE; e++)
                d[(l*NE+e)*OB +: OB] = OB'(gval(0, t, l, e) + gval(1, t, l, e) + ((l == 0) ? b0 : b1));
        return d;
    endfunction

    // Configure, stream stim[] (pass-major) with optional gaps, then wait for done.
    task automatic run_job(input int npass, input int tc_cfg, input int tc_real, input bit relu,
                           input logic [BB*X_PE-1:0] b, input int gap_pct, input bit pulse_cfg);
        out_q.delete(); last_q.delete(); cyc_q.delete();
        done_cnt = 0;
        cfg_num_pass   = PB'(npass);
        cfg_tile_count = (AB+1)'(tc_cfg);
        cfg_relu       = relu;
        bias           = b;
        cfg_valid      = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int p = 0; p < ((npass == 0) ? 1 : npass); p++) begin
            for (int t = 0; t < tc_real; t++) begin
                while ((gap_pct > 0 && $urandom_range(99) < gap_pct) || (pulse_cfg && p == 0 && t == 0)) begin
                    in_valid = 1'b0;
                    if (pulse_cfg) begin
                        cfg_valid      = 1'b1;
                        cfg_num_pass   = 8'd1;
                        cfg_tile_count = (AB+1)'(1);
                        cfg_relu       = 1'b1;
                        bias           = pack_bias(77, -77);
                    end
                    @(posedge clk); #1;
                    cfg_valid = 1'b0;
                    if (pulse_cfg && p == 0 && t == 0) break;
                end
                in_valid   = 1'b1;
                in_data    = stim[p*tc_real + t];
                last_drive = cycle;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 50 && done_cnt == 0; i++)
            @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL job_done: done pulses=%0d required=1", done_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 6;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if ({out_valid, out_last, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_last, done}); end
        if (sat_flag !== 1'b0)  begin n_fail++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
        if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        $display("reset: busy=%b cfg_ready=%b", busy, cfg_ready);
        @(posedge clk); #1;
    endtask

    task automatic test_single_pass();
        stim.delete();
        repeat (3) stim.push_back(pack_lanes(10, 10));
        run_job(1, 3, 3, 1'b0, pack_bias(5, -3), 0, 1'b0);
        n_checks++;
        if (out_q.size() !== 3) begin n_fail++; $display("FAIL single_count: got %0d want 3", out_q.size()); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_checks += 2;
            if (out_q[i] !== pack_lanes(15, 7)) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, out_q[i], pack_lanes(15, 7)); end
            if (last_q[i] !== (i == 2))         begin n_fail++; $display("FAIL single_last[%0d]: got %0b want %0b", i, last_q[i], (i == 2)); end
        end
        if (out_q.size() == 3) begin
            n_checks += 2;
            if (cyc_q[2] - last_drive !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", cyc_q[2] - last_drive); end
            if (done_cyc !== cyc_q[2] + 1)   begin n_fail++; $display("FAIL single_done_cycle: got %0d want %0d", done_cyc, cyc_q[2] + 1); end
        end
        n_checks++;
        if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL single_sat: got %b want 0", sat_flag); end
    endtask

    task automatic test_multi_pass();
        stim.delete();
        repeat (12) stim.push_back(pack_lanes(100, 100));
        run_job(3, 4, 4, 1'b0, pack_bias(1, 1), 0, 1'b0);
        n_checks += 2;
        if (out_q.size() !== 4) begin n_fail++; $display("FAIL multi_count: got %0d want 4", out_q.size()); end
        if (sat_flag !== 1'b0)  begin n_fail++; $display("FAIL multi_sat: got %b want 0", sat_flag); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== pack_lanes(301, 301)) begin n_fail++; $display("FAIL multi_data[%0d]: got %h want %h", i, out_q[i], pack_lanes(301, 301)); end
        end
    endtask

    task automatic test_back_to_back();
        // one tile, four passes of 2^22: clamps at 2^23-1 from pass 2
        stim.delete();
        repeat (4) stim.push_back(pack_lanes(4194304, 4194304));
        run_job(4, 1, 1, 1'b0, pack_bias(0, 0), 0, 1'b0);
        n_checks += 2;
        if (out_q.size() !== 1 || out_q[0] !== pack_lanes(8388607, 8388607)) begin
            n_fail++; $display("FAIL fwd_sat_data: got n=%0d %h want %h", out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, pack_lanes(8388607, 8388607));
        end
        if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL fwd_sat_flag: got %b want 1", sat_flag); end

        stim.delete();
        repeat (3) stim.push_back(pack_lanes(1000, -1000));
        run_job(3, 1, 1, 1'b0, pack_bias(0, 0), 0, 1'b0);
        n_checks += 2;
        if (out_q.size() !== 1 || out_q[0] !== pack_lanes(3000, -3000)) begin
            n_fail++; $display("FAIL fwd_tc1_data: got n=%0d %h want %h", out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, pack_lanes(3000, -3000));
        end
        if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL fwd_tc1_sat_cleared: got %b want 0", sat_flag); end

        stim.delete();
        for (int p = 0; p < 3; p++) begin
            stim.push_back(pack_lanes(7, 7));
            stim.push_back(pack_lanes(11, 11));
        end
        run_job(3, 2, 2, 1'b0, pack_bias(0, 0), 0, 1'b0);
        n_checks++;
        if (out_q.size() !== 2 || out_q[0] !== pack_lanes(21, 21) || out_q[1] !== pack_lanes(33, 33)) begin
            n_fail++; $display("FAIL fwd_tc2_data: got n=%0d want 2 beats of 21/33", out_q.size());
        end

        stim.delete();
        stim.push_back(pack_lanes(-8388608, 5));
        run_job(1, 1, 1, 1'b0, pack_bias(-1, -1), 0, 1'b0);
        n_checks += 2;
        if (out_q.size() !== 1 || out_q[0] !== pack_lanes(-8388608, 4)) begin
            n_fail++; $display("FAIL neg_sat_data: got n=%0d %h want %h", out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, pack_lanes(-8388608, 4));
        end
        if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL neg_sat_flag: got %b want 1", sat_flag); end
    endtask

    task automatic test_relu();
        for (int r = 0; r < 2; r++) begin
            stim.delete();
            stim.push_back(pack_lanes(-50, 60));
            stim.push_back(pack_lanes(20, 20));
            run_job(2, 1, 1, r[0], pack_bias(0, 0), 0, 1'b0);
            n_checks++;
            if (out_q.size() !== 1 || out_q[0] !== pack_lanes((r == 1) ? 0 : -30, 80)) begin
                n_fail++; $display("FAIL relu%0d_data: got n=%0d %h want %h", r, out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, pack_lanes((r == 1) ? 0 : -30, 80));
            end
        end
    endtask

    task automatic test_gaps();
        stim.delete();
        for (int p = 0; p < 2; p++)
            for (int t = 0; t < DEPTH; t++)
                stim.push_back(gap_data(p, t));
        // tile count 0 selects the full depth
        run_job(2, 0, DEPTH, 1'b0, pack_bias(3, -9), 50, 1'b1);
        n_checks++;
        if (out_q.size() !== DEPTH) begin n_fail++; $display("FAIL gaps_count: got %0d want %0d", out_q.size(), DEPTH); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_checks += 2;
            if (out_q[i] !== gap_exp(i, 3, -9)) begin n_fail++; $display("FAIL gaps_data[%0d]: got %h want %h", i, out_q[i], gap_exp(i, 3, -9)); end
            if (last_q[i] !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL gaps_last[%0d]: got %0b", i, last_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int outs_before;
        cfg_num_pass = 8'd3; cfg_tile_count = (AB+1)'(4); cfg_relu = 1'b0; bias = pack_bias(0, 0);
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = pack_lanes(i, i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        done_cnt = 0;
        outs_before = out_q.size();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks += 2;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cfg_ready: got %b want 1", cfg_ready); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt !== 0 || out_q.size() !== outs_before) begin
            n_fail++; $display("FAIL midrst_quiet: done=%0d new outs=%0d want 0/0", done_cnt, out_q.size() - outs_before);
        end
        $display("mid-job reset: busy=%b", busy);
        stim.delete();
        stim.push_back(pack_lanes(1, 1));
        stim.push_back(pack_lanes(1, -4));
        run_job(0, 2, 2, 1'b0, pack_bias(2, 2), 0, 1'b0);
        n_checks++;
        if (out_q.size() !== 2 || out_q[0] !== pack_lanes(3, 3) || out_q[1] !== pack_lanes(3, -2) || last_q[1] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_recover: got n=%0d want 2 beats 3/3 then 3/-2", out_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_back_to_back();
        test_relu();
        test_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psum_accum_buffer.md
Name: psum_accum_buffer

Overview:
- Parametrised successor to the per-PE inter-tile FIFO path: holds partial sums of X_PE Winograd PE lanes across input-channel passes in an internal RAM, with per-job programmable pass count and tile count.
- Adds bias on the first pass, accumulates with saturation, and releases ReLU'd final results on the last pass.
- Sits between the Winograd PE result outputs and the pool blocks; replaces the fixed shift-register read/write timing with a counted, hazard-safe controller.

Parameters:
X_PE, 16, number of PE lanes
RESULT_SIZE, 2, output tile edge; RESULT_SIZE*RESULT_SIZE elements per lane
OUT_BIT, 24, signed element width
BIAS_BIT, 20, signed bias width per lane
DEPTH, 1024, maximum tiles per pass (RAM words)
PASS_BIT, 8, width of pass count
(derived) ADDR_BIT = clog2(DEPTH); LANE_W = OUT_BIT*RESULT_SIZE*RESULT_SIZE; DATA_W = LANE_W*X_PE

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  job configuration strobe
cfg_ready  out  1  high in IDLE only
cfg_num_pass  in  PASS_BIT  passes per job; 0 is treated as 1
cfg_tile_count  in  ADDR_BIT+1  tiles per pass, 1..DEPTH; 0 or >DEPTH is clamped to DEPTH
cfg_relu  in  1  clamp negative final results to 0
bias  in  BIAS_BIT*X_PE  per-lane bias, captured at cfg handshake
in_valid  in  1  PE result beat
in_ready  out  1  high in RUN
in_data  in  DATA_W  PE result, lane i at [i*LANE_W +: LANE_W]
out_valid  out  1  final-result beat
out_data  out  DATA_W  final result, same packing as in_data
out_last  out  1  with out_valid on the final tile of the job
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the final beat
sat_flag  out  1  sticky: any saturation in the current job; cleared at cfg accept

Behaviour:
- Reset (sync, rst_n=0 at clk edge): state=IDLE; all counters 0; out_valid, out_last, done, sat_flag, busy = 0; out_data = 0; RAM contents undefined (never read before write).
- FSM:
  - IDLE -> RUN on cfg_valid && cfg_ready; latch cfg fields and bias.
  - RUN -> DRAIN when a beat is accepted with tile_cnt == tile_count-1 and pass_cnt == num_pass-1.
  - DRAIN -> IDLE after the pipeline empties (2 cycles); done pulses in the cycle of the IDLE transition.
- Counters: tile_cnt increments per accepted beat (in_valid && in_ready); it wraps to 0 at tile_count-1, and pass_cnt increments on each wrap. RAM address = tile_cnt.
- Pipeline: 2 stages; in->out latency is exactly 2 cycles.
  - S0: on acceptance, register in_data and flags (first = pass_cnt==0, last = pass_cnt==num_pass-1); issue RAM read at tile_cnt.
  - S1: per element, sum = in + (first ? sign-extended bias of that lane : rd_data).
    - Sum is computed at OUT_BIT+1 bits, then saturated to the signed OUT_BIT range; set sat_flag on any clamp.
    - If last: out_data = (cfg_relu && sum<0) ? 0 : sum; out_valid=1; out_last = final tile.
    - Otherwise: write sum to RAM at the S1 address; out_valid=0.
- Hazard: with tile_count==1 (or 2 at full rate) a read can hit the address being written in S1. Read-after-write forwarding from the S1 write data is mandatory; results must be identical to non-back-to-back issue.
- Single-pass job: pass is both first and last, so bias is added and output goes direct; no RAM access.
- Gaps in in_valid are allowed anywhere and do not alter results.
- in_valid in IDLE or DRAIN is ignored (in_ready=0); cfg_valid in RUN or DRAIN is ignored.
- Reset mid-job aborts immediately: next cycle IDLE, no done pulse, no further out_valid.
- out has no backpressure; the consumer must always accept.

Decomposition:
- Shared package psum_pkg: state enum (IDLE/RUN/DRAIN), a saturate function (width-parametric), a lane/element slicing helper.
- One sub-module: psum_ram_sdp (simple dual-port, 1-cycle read, DATA_W x DEPTH, write-first not required because forwarding lives in the controller).

Test Plan:
- Single pass, X_PE=2, tile_count=3, bias={5,-3}, inputs with all elements 10 -> out lanes {15,7}, 3 beats, out_last on the 3rd beat, done 1 cycle after it, latency 2.
- 3 passes, tile_count=4, each beat all elements 100, bias 1 -> final outputs 301, emitted only in pass 3; sat_flag=0.
- tile_count=1, 4 passes back-to-back, element 2^22 -> forwarding exercised; positive saturation to 2^23-1 on pass 2 onward; sat_flag=1.
- cfg_relu=1, 2 passes, elements -50 then +20, bias 0 -> out 0; same with cfg_relu=0 -> -30.
- Random in_valid gaps (50%), tile_count=DEPTH, 2 passes -> output matches the zero-gap golden model; cfg_valid pulsed during RUN is ignored.
- rst_n low for 1 cycle mid pass 2 -> busy=0 next cycle, no done, no out_valid; a new cfg is accepted immediately and completes correctly.
